// File: rtl/gesture_stabilizer_pkg.sv
// ============================================================================
// Module   : gesture_stabilizer_pkg
// Brief    : Shared state encodings, gesture constants and the finger-count clamp.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gesture_stabilizer_pkg;

  typedef enum logic [1:0] {
    S_NOHAND = 2'd0,
    S_TRACK  = 2'd1,
    S_LOCKED = 2'd2
  } state_e;

  localparam logic [2:0] GESTURE_HOME = 3'd0;
  localparam logic [2:0] MAX_FINGERS  = 3'd5;

  // The upstream counter can report 6 or 7 on noisy frames; a hand has five fingers.
  function automatic logic [2:0] clamp_count(input logic [2:0] raw);
    return (raw > MAX_FINGERS) ? MAX_FINGERS : raw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gesture_cmd_slot.sv
// ============================================================================
// Module   : gesture_cmd_slot
// Brief    : Single-entry valid/ready command register; latest load wins and an
//            unaccepted command being replaced raises a one-cycle overwrite pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gesture_cmd_slot (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [2:0] load_gesture,
  input  logic       load_hand,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_gesture,
  output logic       cmd_hand,
  output logic       cmd_overwrite
);

  logic       valid_q,     valid_d;
  logic [2:0] gesture_q,   gesture_d;
  logic       hand_q,      hand_d;
  logic       overwrite_q, overwrite_d;

  always_comb begin
    valid_d     = valid_q;
    gesture_d   = gesture_q;
    hand_d      = hand_q;
    overwrite_d = 1'b0;
    if (load) begin
      // A load in the transfer cycle means the old command was taken, not lost.
      valid_d     = 1'b1;
      gesture_d   = load_gesture;
      hand_d      = load_hand;
      overwrite_d = valid_q & ~cmd_ready;
    end else if (valid_q && cmd_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      gesture_q   <= 3'd0;
      hand_q      <= 1'b0;
      overwrite_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      gesture_q   <= gesture_d;
      hand_q      <= hand_d;
      overwrite_q <= overwrite_d;
    end
  end

  assign cmd_valid     = valid_q;
  assign cmd_gesture   = gesture_q;
  assign cmd_hand      = hand_q;
  assign cmd_overwrite = overwrite_q;

endmodule

`default_nettype wire

// File: rtl/gesture_stabilizer.sv
// ============================================================================
// Module   : gesture_stabilizer
// Brief    : Debounces per-frame finger counts into arm commands and reports hand
//            loss. Optional frame watchdog enabled by defining FRAME_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gesture_stabilizer
  import gesture_stabilizer_pkg::*;
#(
  parameter int unsigned STABLE_FRAMES  = 4,
  parameter int unsigned LOST_FRAMES    = 8
`ifdef FRAME_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 2000000
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] finger_count,
  input  logic       count_valid,
  input  logic       hand_detected,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_gesture,
  output logic       cmd_hand,
  output logic       gesture_locked,
  output logic       cmd_overwrite,
  output logic       timeout_flag
);

  localparam logic [3:0] RUN_MAX  = 4'(STABLE_FRAMES);
  localparam logic [7:0] LOST_MAX = 8'(LOST_FRAMES);

  state_e     state_q,     state_d;
  logic [2:0] candidate_q, candidate_d;
  logic [2:0] locked_q,    locked_d;
  logic [3:0] run_cnt_q,   run_cnt_d;
  logic [7:0] lost_cnt_q,  lost_cnt_d;
  logic       load;
  logic [2:0] load_gesture;
  logic       load_hand;
  logic [2:0] count_c;

`ifdef FRAME_TIMEOUT_EN
  localparam logic [31:0] WD_MAX = 32'(TIMEOUT_CYCLES);
  logic [31:0] wd_q, wd_d;
  logic        timeout_q, timeout_d;
`endif

  assign count_c = clamp_count(finger_count);

  always_comb begin
    state_d      = state_q;
    candidate_d  = candidate_q;
    locked_d     = locked_q;
    run_cnt_d    = run_cnt_q;
    lost_cnt_d   = lost_cnt_q;
    load         = 1'b0;
    load_gesture = GESTURE_HOME;
    load_hand    = 1'b0;
`ifdef FRAME_TIMEOUT_EN
    wd_d         = wd_q;
    timeout_d    = timeout_q;
`endif

    if (count_valid) begin
      if (hand_detected) begin
        lost_cnt_d = 8'd0;
        if (count_c == candidate_q) begin
          run_cnt_d = (run_cnt_q == RUN_MAX) ? run_cnt_q : run_cnt_q + 4'd1;
        end else begin
          candidate_d = count_c;
          run_cnt_d   = 4'd1;
        end
        if (state_q == S_NOHAND) state_d = S_TRACK;
        // Run saturates, so an unchanged locked gesture never re-issues.
        if (run_cnt_d == RUN_MAX && (state_q != S_LOCKED || candidate_d != locked_q)) begin
          state_d      = S_LOCKED;
          locked_d     = candidate_d;
          load         = 1'b1;
          load_gesture = candidate_d;
          load_hand    = 1'b1;
        end
      end else begin
        run_cnt_d = 4'd0;
        if (lost_cnt_q != LOST_MAX) begin
          lost_cnt_d = lost_cnt_q + 8'd1;
          if (lost_cnt_d == LOST_MAX) begin
            state_d      = S_NOHAND;
            candidate_d  = GESTURE_HOME;
            load         = 1'b1;
            load_gesture = GESTURE_HOME;
            load_hand    = 1'b0;
          end
        end
      end
`ifdef FRAME_TIMEOUT_EN
      wd_d      = 32'd0;
      timeout_d = 1'b0;
    end else if (wd_q != WD_MAX) begin
      wd_d = wd_q + 32'd1;
      if (wd_d == WD_MAX) begin
        // Stalled camera: treat as lost now, with lost_cnt saturated so frames don't re-home.
        timeout_d   = 1'b1;
        state_d     = S_NOHAND;
        candidate_d = GESTURE_HOME;
        run_cnt_d   = 4'd0;
        lost_cnt_d  = LOST_MAX;
        if (state_q == S_LOCKED) begin
          load         = 1'b1;
          load_gesture = GESTURE_HOME;
          load_hand    = 1'b0;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_NOHAND;
      candidate_q <= GESTURE_HOME;
      locked_q    <= GESTURE_HOME;
      run_cnt_q   <= 4'd0;
      lost_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      candidate_q <= candidate_d;
      locked_q    <= locked_d;
      run_cnt_q   <= run_cnt_d;
      lost_cnt_q  <= lost_cnt_d;
    end
  end

`ifdef FRAME_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_q      <= 32'd0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout_flag = timeout_q;
`else
  assign timeout_flag = 1'b0;
`endif

  assign gesture_locked = (state_q == S_LOCKED);

  gesture_cmd_slot u_cmd_slot (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (load),
    .load_gesture  (load_gesture),
    .load_hand     (load_hand),
    .cmd_ready     (cmd_ready),
    .cmd_valid     (cmd_valid),
    .cmd_gesture   (cmd_gesture),
    .cmd_hand      (cmd_hand),
    .cmd_overwrite (cmd_overwrite)
  );

endmodule

`default_nettype wire

// File: tb/tb_gesture_stabilizer.sv
// ============================================================================
// Module   : tb_gesture_stabilizer
// Brief    : Directed scenarios followed by random frames, every cycle compared
//            against a frame-level reference model. Timeout case needs FRAME_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gesture_stabilizer;

  localparam int STABLE = 4;
  localparam int LOST   = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] finger_count = 3'd0;
  logic       count_valid = 1'b0;
  logic       hand_detected = 1'b0;
  logic       cmd_ready = 1'b1;
  logic       cmd_valid;
  logic [2:0] cmd_gesture;
  logic       cmd_hand;
  logic       gesture_locked;
  logic       cmd_overwrite;
  logic       timeout_flag;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gesture_stabilizer #(
    .STABLE_FRAMES (STABLE),
    .LOST_FRAMES   (LOST)
`ifdef FRAME_TIMEOUT_EN
    , .TIMEOUT_CYCLES (100)
`endif
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .finger_count   (finger_count),
    .count_valid    (count_valid),
    .hand_detected  (hand_detected),
    .cmd_ready      (cmd_ready),
    .cmd_valid      (cmd_valid),
    .cmd_gesture    (cmd_gesture),
    .cmd_hand       (cmd_hand),
    .gesture_locked (gesture_locked),
    .cmd_overwrite  (cmd_overwrite),
    .timeout_flag   (timeout_flag)
  );

  // Reference: gesture history expressed as run lengths and a pending-command slot.
  int m_cand, m_run, m_lost, m_lg;
  bit m_locked;
  bit e_valid, e_hand, e_ow;
  int e_gest;
  int exp_xfers = 0;
  int obs_xfers = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_tick(input bit cv, input bit hand, input int fc, input bit rdy, input bit rst);
    bit cmd = 0;
    int g = 0;
    bit h = 0;
    int c;
    if (rst) begin
      m_cand = 0; m_run = 0; m_lost = 0; m_lg = 0; m_locked = 0;
      e_valid = 0; e_hand = 0; e_gest = 0; e_ow = 0;
      return;
    end
    if (cv) begin
      if (hand) begin
        m_lost = 0;
        c = (fc > 5) ? 5 : fc;
        if (c == m_cand) m_run++;
        else begin m_cand = c; m_run = 1; end
        if (m_run == STABLE && (!m_locked || m_cand != m_lg)) begin
          m_locked = 1; m_lg = m_cand; cmd = 1; g = m_cand; h = 1;
        end
      end else begin
        m_run = 0;
        m_lost++;
        if (m_lost == LOST) begin
          m_locked = 0; m_cand = 0; cmd = 1; g = 0; h = 0;
        end
      end
    end
    e_ow = 0;
    if (cmd) begin
      if (e_valid && rdy) exp_xfers++;
      e_ow = e_valid && !rdy;
      e_valid = 1; e_gest = g; e_hand = h;
    end else if (e_valid && rdy) begin
      e_valid = 0;
      exp_xfers++;
    end
  endtask

  task automatic step(input bit cv, input bit hand, input int fc, input bit rdy, input bit rst);
    count_valid   = cv;
    hand_detected = hand;
    finger_count  = 3'(fc);
    cmd_ready     = rdy;
    rst_n         = ~rst;
    if (cmd_valid === 1'b1 && rdy && !rst) obs_xfers++;
    model_tick(cv, hand, fc, rdy, rst);
    @(posedge clk);
    #1;
    chk("cmd_valid",      int'(cmd_valid),      int'(e_valid));
    chk("cmd_gesture",    int'(cmd_gesture),    e_valid ? e_gest : int'(cmd_gesture === 3'bx ? 0 : cmd_gesture));
    chk("cmd_hand",       int'(cmd_hand),       e_valid ? int'(e_hand) : int'(cmd_hand === 1'bx ? 0 : cmd_hand));
    chk("gesture_locked", int'(gesture_locked), int'(m_locked));
    chk("cmd_overwrite",  int'(cmd_overwrite),  int'(e_ow));
    chk("timeout_flag",   int'(timeout_flag),   0);
  endtask

  task automatic frames(input int n, input bit hand, input int fc, input bit rdy);
    for (int i = 0; i < n; i++) begin
      step(1, hand, fc, rdy, 0);
      if (i != n - 1) step(0, 0, 0, rdy, 0);
    end
  endtask

  task automatic do_reset();
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    chk("reset_valid",  int'(cmd_valid), 0);
    chk("reset_locked", int'(gesture_locked), 0);
    chk("reset_gest",   int'(cmd_gesture), 0);
    chk("reset_hand",   int'(cmd_hand), 0);
  endtask

  initial begin
    int fc_r;
    bit dark;
    do_reset();

    // 1: four frames of 3 lock and command gesture 3 the cycle after the 4th frame
    frames(4, 1, 3, 1);
    chk("t1_valid", int'(cmd_valid), 1);
    chk("t1_gest",  int'(cmd_gesture), 3);
    chk("t1_hand",  int'(cmd_hand), 1);
    chk("t1_lock",  int'(gesture_locked), 1);
    step(0, 0, 0, 1, 0);
    chk("t1_drop",  int'(cmd_valid), 0);

    // 2: a glitch restarts the run
    do_reset();
    frames(2, 1, 3, 1); frames(1, 1, 2, 1); frames(3, 1, 3, 1);
    chk("t2_early", int'(cmd_valid), 0);
    frames(1, 1, 3, 1);
    chk("t2_gest",  int'(cmd_gesture), 3);
    step(0, 0, 0, 1, 0);
    frames(3, 1, 3, 1);
    chk("t2_norepeat", int'(cmd_valid), 0);

    // 3: relock to 5 while locked
    frames(4, 1, 5, 1);
    chk("t3_gest", int'(cmd_gesture), 5);
    chk("t3_lock", int'(gesture_locked), 1);
    step(0, 0, 0, 1, 0);

    // 4: interrupted loss does not home; a full loss does
    frames(7, 0, 0, 1); frames(1, 1, 3, 1); frames(7, 0, 0, 1);
    chk("t4_notyet", int'(gesture_locked), 1);
    step(0, 0, 0, 1, 0);
    frames(1, 0, 0, 1);
    chk("t4_valid", int'(cmd_valid), 1);
    chk("t4_hand",  int'(cmd_hand), 0);
    chk("t4_gest",  int'(cmd_gesture), 0);
    chk("t4_lock",  int'(gesture_locked), 0);
    step(0, 0, 0, 1, 0);

    // 5: stalled consumer sees the newer gesture only, exactly once
    do_reset();
    frames(4, 1, 3, 0); frames(3, 1, 5, 0);
    frames(1, 1, 5, 0);
    chk("t5_ow",   int'(cmd_overwrite), 1);
    chk("t5_gest", int'(cmd_gesture), 5);
    obs_xfers = 0; exp_xfers = 0;
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
    chk("t5_xfers", obs_xfers, 1);
    chk("t5_model_xfers", obs_xfers, exp_xfers);

    // 6: out-of-range counts clamp, and reset clears a pending command
    do_reset();
    frames(4, 1, 7, 0);
    chk("t6_gest", int'(cmd_gesture), 5);
    step(0, 0, 0, 0, 1);
    chk("t6_valid", int'(cmd_valid), 0);
    chk("t6_lock",  int'(gesture_locked), 0);
    step(0, 0, 0, 1, 0);

`ifdef FRAME_TIMEOUT_EN
    // 7: locked then the frame stream stops
    do_reset();
    frames(4, 1, 2, 1);
    step(0, 0, 0, 1, 0);
    count_valid = 0;
    begin
      bit seen = 0;
      for (int i = 0; i < 150 && !seen; i++) begin
        @(posedge clk); #1;
        seen = timeout_flag;
      end
      chk("t7_flag",  int'(timeout_flag), 1);
      chk("t7_valid", int'(cmd_valid), 1);
      chk("t7_hand",  int'(cmd_hand), 0);
      chk("t7_gest",  int'(cmd_gesture), 0);
      chk("t7_lock",  int'(gesture_locked), 0);
    end
`endif

    // Random frames, with dark stretches long enough to lose the hand
    do_reset();
    obs_xfers = 0; exp_xfers = 0;
    fc_r = 3; dark = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) dark = ~dark;
      if ($urandom_range(0, 3) == 0) fc_r = $urandom_range(0, 7);
      step($urandom_range(0, 2) == 0,
           dark ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) != 0),
           fc_r, $urandom_range(0, 9) < 7, $urandom_range(0, 499) == 0);
    end
    chk("rand_xfers", obs_xfers, exp_xfers);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
